// File: rtl/program_counter.sv
// Free-running instruction-address counter for the picoMIPS core.
// Steps once per clock unless halted; any branch or jump selection lives outside this block.
module program_counter #(
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                halt,
    output logic [PC_WIDTH-1:0] pc
);

    // pc is the register itself, so the output cannot glitch and halt never reaches it combinationally
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pc <= RESET_VALUE;
        end else if (!halt) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed vector table, corner sequences,
// and randomized halt/reset traffic against a count-of-enabled-edges reference model.
module tb_program_counter;

    logic       clk;
    logic       n_reset;
    logic       halt;
    logic [7:0] pc;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic       n_reset;
        logic       halt;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vectors[17];

    program_counter #(
        .PC_WIDTH   (8),
        .RESET_VALUE(8'h00),
        .PC_STEP    (8'h01)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .halt   (halt),
        .pc     (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] expected);
        compared++;
        if (pc !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: pc=0x%02h expected=0x%02h", name, $time, pc, expected);
        end
    endtask

    // Drive inputs away from the active edge, then sample just after the next rising edge
    task automatic apply_stimulus(input logic rst_val, input logic halt_val);
        n_reset = rst_val;
        halt    = halt_val;
        @(posedge clk);
        #1;
    endtask

    task automatic run_edges(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            apply_stimulus(1'b1, 1'b0);
        end
    endtask

    initial begin
        int enabled_edges;
        logic [7:0] expected;

        n_reset = 1'b0;
        halt    = 1'b0;

        vectors[0]  = '{1'b0, 1'b0, 8'h00};
        vectors[1]  = '{1'b0, 1'b0, 8'h00};
        vectors[2]  = '{1'b1, 1'b0, 8'h01};
        vectors[3]  = '{1'b1, 1'b0, 8'h02};
        vectors[4]  = '{1'b1, 1'b0, 8'h03};
        vectors[5]  = '{1'b1, 1'b0, 8'h04};
        vectors[6]  = '{1'b1, 1'b0, 8'h05};
        vectors[7]  = '{1'b1, 1'b1, 8'h05};
        vectors[8]  = '{1'b1, 1'b1, 8'h05};
        vectors[9]  = '{1'b1, 1'b1, 8'h05};
        vectors[10] = '{1'b1, 1'b1, 8'h05};
        vectors[11] = '{1'b1, 1'b1, 8'h05};
        vectors[12] = '{1'b1, 1'b0, 8'h06};
        vectors[13] = '{1'b1, 1'b0, 8'h07};
        vectors[14] = '{1'b1, 1'b0, 8'h08};
        vectors[15] = '{1'b1, 1'b0, 8'h09};
        vectors[16] = '{1'b1, 1'b0, 8'h0A};

        #1;
        check_output("reset_before_edge", 8'h00);
        #(-1 + 1);

        // Vector i is driven on a falling edge and checked right after the following rising edge
        for (int i = 0; i < 17; i++) begin
            if (i > 0) @(negedge clk);
            apply_stimulus(vectors[i].n_reset, vectors[i].halt);
            check_output($sformatf("vector_%0d", i), vectors[i].exp_pc);
        end

        // Wrap-around from 0xFF
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        check_output("async_clear_before_wrap", 8'h00);
        run_edges(255);
        check_output("wrap_reach_ff", 8'hFF);
        run_edges(1);
        check_output("wrap_to_00", 8'h00);
        run_edges(1);
        check_output("wrap_then_01", 8'h01);

        // Reset pulled mid-cycle while halted at 0x37
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        check_output("async_clear_before_37", 8'h00);
        run_edges(8'h37);
        check_output("reach_37", 8'h37);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1);
        check_output("halt_at_37", 8'h37);
        #2;
        n_reset = 1'b0;
        #1;
        check_output("async_reset_mid_cycle", 8'h00);
        @(posedge clk);
        #1;
        check_output("reset_held_over_edge", 8'h00);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0);
        check_output("release_first_edge", 8'h01);

        // Randomized traffic: the model only counts edges that saw reset released and halt low
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        check_output("random_start_clear", 8'h00);
        enabled_edges = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_reset = ($urandom_range(0, 15) != 0);
            halt    = $urandom_range(0, 1) == 1;
            if (!n_reset) begin
                enabled_edges = 0;
                #1;
                check_output("random_async_clear", 8'h00);
            end
            @(posedge clk);
            if (n_reset && !halt) enabled_edges++;
            #1;
            expected = 8'((enabled_edges * 1) % 256);
            check_output("random_count", expected);
            // Mid-cycle halt glitch must not affect the count
            halt = ~halt;
            #2;
            halt = ~halt;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
